// File: rtl/ram_responder_pkg.sv
// Shared types for the ram_responder block: write delay-stage request and read-pipe stage.
// Struct fields are sized for the widest supported configuration; narrower builds zero-extend.
package ram_responder_pkg;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 64;
  localparam int MAX_ADDR_WIDTH   = 16;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      en;
  } wr_req_t;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      valid;
  } rd_stage_t;

endpackage

// File: rtl/ram_responder_if.sv
// Initiator-side memory port bundle: read address/enable/data/valid and write address/data/enable.
interface ram_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] raddr_0;
  logic                  ren_0;
  logic [DATA_WIDTH-1:0] rdata_0;
  logic                  rvalid_0;
  logic [ADDR_WIDTH-1:0] waddr_0;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic                  wen_0;

  modport master (
    output raddr_0, ren_0, waddr_0, wdata_0, wen_0,
    input  rdata_0, rvalid_0
  );

  modport slave (
    input  raddr_0, ren_0, waddr_0, wdata_0, wen_0,
    output rdata_0, rvalid_0
  );

endinterface

// File: rtl/ram_responder_pipe_read_pipe.sv
// rr_read_pipe: LATENCY-deep shift register of read responses; each stage holds its data
// when no valid response passes through, so the output data is sticky between responses.
import ram_responder_pkg::*;

module rr_read_pipe #(
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_stage_t in_i,
  output rd_stage_t out_o
);

  localparam int L = (LATENCY < 1) ? 1 :
                     ((LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : LATENCY);

  rd_stage_t stage_q [L];
  rd_stage_t stage_d [L];

  always_comb begin
    stage_d[0]       = stage_q[0];
    stage_d[0].valid = 1'b0;
    if (in_i.valid) begin
      stage_d[0] = in_i;
    end
    for (int i = 1; i < L; i++) begin
      stage_d[i]       = stage_q[i];
      stage_d[i].valid = 1'b0;
      if (stage_q[i-1].valid) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < L; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_o = stage_q[L-1];

endmodule

// File: rtl/ram_responder_pipe.sv
// ram_responder_pipe: memory responder with configurable read latency, delayed write commit,
// debug access and access counters. Define RAM_RESPONDER_BYPASS_EN to forward the pending write.
import ram_responder_pkg::*;

module ram_responder_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_responder_if.slave        bus,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data,
  input  logic [ADDR_WIDTH-1:0] debug_write_addr,
  input  logic [DATA_WIDTH-1:0] debug_write_data,
  input  logic                  debug_write_en,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  wr_req_t               wr_q, wr_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] rd_word;
  rd_stage_t             rd_in, rd_out;
  logic                  unused_ok;

  always_comb begin
    wr_d                        = '0;
    wr_d.addr[ADDR_WIDTH-1:0]   = bus.waddr_0;
    wr_d.data[DATA_WIDTH-1:0]   = bus.wdata_0;
    wr_d.en                     = bus.wen_0;

    rd_word = mem_q[bus.raddr_0];
`ifdef RAM_RESPONDER_BYPASS_EN
    // Only the pending (not yet committed) write is forwarded; a same-edge request is not.
    if (wr_q.en && (wr_q.addr[ADDR_WIDTH-1:0] == bus.raddr_0)) begin
      rd_word = wr_q.data[DATA_WIDTH-1:0];
    end
`endif

    rd_in                       = '0;
    rd_in.data[DATA_WIDTH-1:0]  = rd_word;
    rd_in.valid                 = bus.ren_0;

    rd_cnt_d = rd_cnt_q + CNT_WIDTH'(bus.ren_0);
    wr_cnt_d = wr_cnt_q + CNT_WIDTH'(wr_q.en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Array contents survive reset; the debug write is ordered last so it wins on collision.
  always_ff @(posedge clk) begin
    if (!rst && wr_q.en) begin
      mem_q[wr_q.addr[ADDR_WIDTH-1:0]] <= wr_q.data[DATA_WIDTH-1:0];
    end
    if (debug_write_en) begin
      mem_q[debug_write_addr] <= debug_write_data;
    end
  end

  rr_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (rd_in),
    .out_o (rd_out)
  );

  assign bus.rdata_0  = rd_out.data[DATA_WIDTH-1:0];
  assign bus.rvalid_0 = rd_out.valid;
  assign debug_data   = mem_q[debug_addr];
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

  // Upper struct bits beyond the configured widths are constant zero.
  assign unused_ok = ^{rd_out.data, wr_q.addr, wr_q.data};

endmodule

// File: tb/tb_ram_responder_pipe.sv
// Directed bench for ram_responder_pipe: table-driven vectors at latency 1 plus hand
// sequences for latency 3 back-to-back reads and mid-operation reset at latency 2.
module tb_ram_responder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic byp;

  ram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  ram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();
  ram_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_c ();

  logic        rst_a, rst_b, rst_c;
  logic [4:0]  da_a, dwa_a, da_b, dwa_b, da_c, dwa_c;
  logic [31:0] dd_a, dwd_a, dd_b, dwd_b, dd_c, dwd_c;
  logic        dwe_a, dwe_b, dwe_c;
  logic [3:0]  rc_a, wc_a;
  logic [15:0] rc_b, wc_b, rc_c, wc_c;

  ram_responder_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave),
    .debug_addr(da_a), .debug_data(dd_a),
    .debug_write_addr(dwa_a), .debug_write_data(dwd_a), .debug_write_en(dwe_a),
    .rd_count(rc_a), .wr_count(wc_a)
  );

  ram_responder_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(3), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave),
    .debug_addr(da_b), .debug_data(dd_b),
    .debug_write_addr(dwa_b), .debug_write_data(dwd_b), .debug_write_en(dwe_b),
    .rd_count(rc_b), .wr_count(wc_b)
  );

  ram_responder_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(2), .CNT_WIDTH(16)) u_c (
    .clk(clk), .rst(rst_c), .bus(bus_c.slave),
    .debug_addr(da_c), .debug_data(dd_c),
    .debug_write_addr(dwa_c), .debug_write_data(dwd_c), .debug_write_en(dwe_c),
    .rd_count(rc_c), .wr_count(wc_c)
  );

  typedef struct {
    logic        ren;
    logic [4:0]  raddr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        dwe;
    logic [4:0]  dwa;
    logic [31:0] dwd;
    logic [4:0]  da;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [3:0]  exp_rc;
    logic [3:0]  exp_wc;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic ren, input logic [4:0] raddr,
                              input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic dwe, input logic [4:0] dwa, input logic [31:0] dwd,
                              input logic [4:0] da, input logic exp_rv, input logic [31:0] exp_rd,
                              input logic [3:0] exp_rc, input logic [3:0] exp_wc,
                              input logic [31:0] exp_dbg);
    vec_t v;
    v.ren = ren; v.raddr = raddr; v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.dwe = dwe; v.dwa = dwa; v.dwd = dwd; v.da = da;
    v.exp_rv = exp_rv; v.exp_rd = exp_rd; v.exp_rc = exp_rc; v.exp_wc = exp_wc;
    v.exp_dbg = exp_dbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd_w1, rd_w2;
    logic        rv_seq [6];
    logic [31:0] rd_seq [6];

`ifdef RAM_RESPONDER_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rd_w1 = byp ? 32'd17 : 32'd1;
    rd_w2 = byp ? 32'd20 : 32'd9;

    //               ren raddr wen waddr wdata dwe dwa dwd da  rv rd     rc wc dbg
    vecs[0]  = mk(0, 0, 0, 0, 0,  1, 0, 12, 0, 0, 0,     0, 0, 12);
    vecs[1]  = mk(0, 0, 0, 0, 0,  1, 3, 1,  3, 0, 0,     0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0,  1, 4, 9,  4, 0, 0,     0, 0, 9);
    vecs[3]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 1, 12,    1, 0, 12);
    vecs[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 12,    1, 0, 12);
    vecs[5]  = mk(1, 3, 1, 3, 17, 0, 0, 0,  3, 1, 1,     2, 0, 1);
    vecs[6]  = mk(1, 3, 0, 0, 0,  0, 0, 0,  3, 1, rd_w1, 3, 1, 17);
    vecs[7]  = mk(1, 3, 0, 0, 0,  0, 0, 0,  3, 1, 17,    4, 1, 17);
    vecs[8]  = mk(0, 0, 1, 4, 20, 0, 0, 0,  4, 0, 17,    4, 1, 9);
    vecs[9]  = mk(1, 4, 0, 0, 0,  0, 0, 0,  4, 1, rd_w2, 5, 2, 20);
    vecs[10] = mk(0, 0, 0, 0, 0,  0, 0, 0,  4, 0, rd_w2, 5, 2, 20);
    vecs[11] = mk(0, 0, 1, 6, 1,  1, 6, 0,  6, 0, rd_w2, 5, 2, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,  1, 6, 2,  6, 0, rd_w2, 5, 3, 2);
    vecs[13] = mk(0, 0, 0, 0, 0,  0, 0, 0,  6, 0, rd_w2, 5, 3, 2);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.ren_0 = 0; bus_a.raddr_0 = 0; bus_a.wen_0 = 0; bus_a.waddr_0 = 0; bus_a.wdata_0 = 0;
    bus_b.ren_0 = 0; bus_b.raddr_0 = 0; bus_b.wen_0 = 0; bus_b.waddr_0 = 0; bus_b.wdata_0 = 0;
    bus_c.ren_0 = 0; bus_c.raddr_0 = 0; bus_c.wen_0 = 0; bus_c.waddr_0 = 0; bus_c.wdata_0 = 0;
    da_a = 0; dwa_a = 0; dwd_a = 0; dwe_a = 0;
    da_b = 0; dwa_b = 0; dwd_b = 0; dwe_b = 0;
    da_c = 0; dwa_c = 0; dwd_c = 0; dwe_c = 0;
    step();
    step();
    check("reset_rvalid", 32'(bus_a.rvalid_0), 32'd0);
    check("reset_rdata", bus_a.rdata_0, 32'd0);
    check("reset_rd_count", 32'(rc_a), 32'd0);
    check("reset_wr_count", 32'(wc_a), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Latency-1 vector table
    for (int i = 0; i < 14; i++) begin
      bus_a.ren_0 = vecs[i].ren; bus_a.raddr_0 = vecs[i].raddr;
      bus_a.wen_0 = vecs[i].wen; bus_a.waddr_0 = vecs[i].waddr; bus_a.wdata_0 = vecs[i].wdata;
      dwe_a = vecs[i].dwe; dwa_a = vecs[i].dwa; dwd_a = vecs[i].dwd; da_a = vecs[i].da;
      step();
      check($sformatf("v%0d_rvalid", i), 32'(bus_a.rvalid_0), 32'(vecs[i].exp_rv));
      check($sformatf("v%0d_rdata", i), bus_a.rdata_0, vecs[i].exp_rd);
      check($sformatf("v%0d_rd_count", i), 32'(rc_a), 32'(vecs[i].exp_rc));
      check($sformatf("v%0d_wr_count", i), 32'(wc_a), 32'(vecs[i].exp_wc));
      check($sformatf("v%0d_debug_data", i), dd_a, vecs[i].exp_dbg);
    end

    // Counter wrap on the 4-bit read counter (currently 5)
    bus_a.ren_0 = 1; bus_a.raddr_0 = 0; bus_a.wen_0 = 0; dwe_a = 0;
    for (int i = 0; i < 10; i++) step();
    check("wrap_rd_count_15", 32'(rc_a), 32'd15);
    step();
    check("wrap_rd_count_0", 32'(rc_a), 32'd0);
    check("wrap_rdata", bus_a.rdata_0, 32'd12);
    bus_a.ren_0 = 0;

    // Latency-3 back-to-back reads of addr 1,2,3 holding 5,6,7
    for (int i = 1; i <= 3; i++) begin
      dwe_b = 1; dwa_b = 5'(i); dwd_b = 32'(i + 4);
      step();
    end
    dwe_b = 0;
    rv_seq = '{0, 0, 1, 1, 1, 0};
    rd_seq = '{0, 0, 5, 6, 7, 7};
    for (int i = 0; i < 6; i++) begin
      bus_b.ren_0 = (i < 3); bus_b.raddr_0 = 5'(i + 1);
      step();
      check($sformatf("l3_c%0d_rvalid", i), 32'(bus_b.rvalid_0), 32'(rv_seq[i]));
      check($sformatf("l3_c%0d_rdata", i), bus_b.rdata_0, rd_seq[i]);
    end
    check("l3_rd_count", 32'(rc_b), 32'd3);
    check("l3_wr_count", 32'(wc_b), 32'd0);

    // Latency-2 reset one cycle after accepting a read and a write
    dwe_c = 1; dwa_c = 5; dwd_c = 33; da_c = 5;
    step();
    dwe_c = 0;
    bus_c.ren_0 = 1; bus_c.raddr_0 = 5; bus_c.wen_0 = 1; bus_c.waddr_0 = 5; bus_c.wdata_0 = 44;
    step();
    check("rst_mid_rd_count_pre", 32'(rc_c), 32'd1);
    check("rst_mid_rvalid_e0", 32'(bus_c.rvalid_0), 32'd0);
    bus_c.ren_0 = 0; bus_c.wen_0 = 0; rst_c = 1;
    step();
    check("rst_mid_rvalid_e1", 32'(bus_c.rvalid_0), 32'd0);
    check("rst_mid_rd_count", 32'(rc_c), 32'd0);
    check("rst_mid_wr_count", 32'(wc_c), 32'd0);
    rst_c = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_mid_after%0d_rvalid", i), 32'(bus_c.rvalid_0), 32'd0);
      check($sformatf("rst_mid_after%0d_word", i), dd_c, 32'd33);
      check($sformatf("rst_mid_after%0d_wr_count", i), 32'(wc_c), 32'd0);
    end
    check("rst_mid_rdata", bus_c.rdata_0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
